// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the PLL/BUFGCE/consumer side.
// Latency: none, signal grouping only.
// Backpressure: none; all signals are level or single-cycle pulses.
interface pll_reset_sequencer_if #(
  parameter int RELOCK_W = 8
);
  logic                pll_locked;
  logic                restart;
  logic                pll_rst;
  logic                clk_en;
  logic                out_rst_n;
  logic                ready;
  logic                fault;
  logic [2:0]          state;
  logic [RELOCK_W-1:0] relock_count;

  modport master (
    input  pll_locked, restart,
    output pll_rst, clk_en, out_rst_n, ready, fault, state, relock_count
  );

  modport slave (
    output pll_locked, restart,
    input  pll_rst, clk_en, out_rst_n, ready, fault, state, relock_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock wait, stabilisation and BUFGCE enable; retries, then parks in FAULT.
// Latency: locked_s first high -> clk_en at +STABLE_CYCLES+1, out_rst_n one cycle after clk_en.
// Backpressure: none; restart is honoured on any cycle and overrides every other transition.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16,
  parameter int RELOCK_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pll_reset_sequencer_if.master  bus
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [RELOCK_W-1:0] RELOCK_ONE = RELOCK_W'(1);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  logic                locked_q1;
  logic                locked_s;

  state_t              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [RETRY_W-1:0]  retries_q, retries_d;
  logic [RELOCK_W-1:0] relock_q,  relock_d;

  logic                pll_rst_q;
  logic                clk_en_q;
  logic                out_rst_n_q;
  logic                ready_q;
  logic                fault_q;

  // Two-flop synchroniser bringing the asynchronous LOCKED into the reference domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q1 <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      locked_q1 <= bus.pll_locked;
      locked_s  <= locked_q1;
    end
  end

  // Sequencer state, shared cycle counter, retry and lock-loss bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retries_q <= '0;
      relock_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      relock_q  <= relock_d;
    end
  end

  // Next-state logic; every transition clears cnt so it never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    retries_d = retries_q;
    relock_d  = relock_q;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // A lock seen on the timeout cycle still wins.
        if (locked_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          retries_d = retries_q + RETRY_ONE;
          cnt_d     = '0;
          state_d   = ((retries_q + RETRY_ONE) == RETRY_MAX) ? FAULT : RESET_PLL;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = RUN;
          cnt_d     = '0;
          retries_d = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = RESET_PLL;
          if (relock_q != {RELOCK_W{1'b1}}) begin
            relock_d = relock_q + RELOCK_ONE;
          end
        end
      end
      FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // Restart abandons whatever is in progress but keeps the lock-loss history.
    if (bus.restart) begin
      state_d   = RESET_PLL;
      cnt_d     = '0;
      retries_d = '0;
    end
  end

  // Registered outputs decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      clk_en_q    <= 1'b0;
      out_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      pll_rst_q   <= (state_d == RESET_PLL);
      clk_en_q    <= (state_d == RUN);
      // Release one cycle after the clock is enabled, assert together with the gate closing.
      out_rst_n_q <= (state_d == RUN) & clk_en_q;
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.clk_en       = clk_en_q;
  assign bus.out_rst_n    = out_rst_n_q;
  assign bus.ready        = ready_q;
  assign bus.fault        = fault_q;
  assign bus.state        = state_q;
  assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for the PLL reset sequencer using small parameters.
// Latency: observed values sampled on the falling edge after each stepped rising edge.
// Backpressure: not applicable; inputs are driven as levels and single-edge pulses.
module tb_pll_reset_sequencer;

  logic clk;
  logic rst_n;

  pll_reset_sequencer_if #(.RELOCK_W(2)) bus ();

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (16),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .CNT_W        (16),
    .RELOCK_W     (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word layout: {state[2:0], pll_rst, clk_en, out_rst_n, ready, fault, relock[1:0]}
  typedef struct {
    int         n;
    logic       lk;
    logic       rs;
    logic [9:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [9:0] pk(input logic [2:0] st, input logic prst, input logic cen,
                                    input logic orn, input logic rdy, input logic flt,
                                    input logic [1:0] rc);
    return {st, prst, cen, orn, rdy, flt, rc};
  endfunction

  function automatic logic [9:0] obs();
    return {bus.state, bus.pll_rst, bus.clk_en, bus.out_rst_n, bus.ready, bus.fault,
            bus.relock_count};
  endfunction

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (state,pll_rst,clk_en,out_rst_n,ready,fault,relock)",
               nm, act, exp);
    end
  endtask

  task automatic add(input int n, input logic lk, input logic rs, input logic [9:0] exp);
    vec_t v;
    v.n = n; v.lk = lk; v.rs = rs; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      bus.pll_locked = vq[i].lk;
      bus.restart    = vq[i].rs;
      repeat (vq[i].n) @(posedge clk);
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), obs(), vq[i].exp);
    end
    bus.restart = 1'b0;
    vq.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;
    #2;
    check({tag, "_in_reset"}, obs(), pk(3'd0, 1, 0, 0, 0, 0, 2'd0));
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    for (int i = 0; i < budget && bus.state !== st; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check(tag, {7'd0, bus.state}, {7'd0, st});
  endtask

  localparam logic [9:0] W0  = 10'b001_0_0_0_0_0_00;
  localparam logic [9:0] S0  = 10'b010_0_0_0_0_0_00;
  localparam logic [9:0] R0  = 10'b000_1_0_0_0_0_00;
  localparam logic [9:0] F0  = 10'b100_0_0_0_0_1_00;
  localparam logic [9:0] RA0 = 10'b011_0_1_0_1_0_00;
  localparam logic [9:0] RB0 = 10'b011_0_1_1_1_0_00;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;

    // Start-up, first lock and one lock loss in RUN.
    do_reset("startup");
    add(3,  0, 0, R0);
    add(1,  0, 0, W0);
    add(5,  0, 0, W0);
    add(1,  1, 0, W0);
    add(1,  1, 0, W0);
    add(1,  1, 0, S0);
    add(7,  1, 0, S0);
    add(1,  1, 0, RA0);
    add(1,  1, 0, RB0);
    add(1,  0, 0, RB0);
    add(1,  0, 0, RB0);
    add(1,  0, 0, pk(3'd0, 1, 0, 0, 0, 0, 2'd1));
    add(3,  0, 0, pk(3'd0, 1, 0, 0, 0, 0, 2'd1));
    add(1,  0, 0, pk(3'd1, 0, 0, 0, 0, 0, 2'd1));
    run_vecs("startup");

    // Further lock losses: relock_count saturates at 3.
    for (int k = 2; k <= 4; k++) begin
      bus.pll_locked = 1'b1;
      wait_state($sformatf("relock%0d_run", k), 3'd3, 40);
      bus.pll_locked = 1'b0;
      wait_state($sformatf("relock%0d_drop", k), 3'd0, 10);
      check($sformatf("relock%0d_count", k), {8'd0, bus.relock_count},
            {8'd0, (k > 3) ? 2'd3 : 2'(k)});
    end

    // Asynchronous reset in the middle of STABILIZE clears everything without a clock edge.
    bus.pll_locked = 1'b1;
    wait_state("async_reach_stab", 3'd2, 30);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mid_stab", obs(), pk(3'd0, 1, 0, 0, 0, 0, 2'd0));

    // No lock: two attempts then FAULT, cleared by restart.
    do_reset("fault");
    add(19, 0, 0, W0);
    add(1,  0, 0, R0);
    add(19, 0, 0, W0);
    add(1,  0, 0, F0);
    add(5,  0, 0, F0);
    add(1,  0, 1, R0);
    add(1,  0, 0, R0);
    run_vecs("fault");

    // Lock lost on the 5th STABILIZE cycle; re-lock needs the full window again.
    do_reset("stab_drop");
    add(9,  0, 0, W0);
    add(5,  1, 0, S0);
    add(1,  0, 0, S0);
    add(1,  0, 0, S0);
    add(1,  0, 0, W0);
    add(2,  1, 0, W0);
    add(1,  1, 0, S0);
    add(7,  1, 0, S0);
    add(1,  1, 0, RA0);
    run_vecs("stab_drop");

    // Restart coinciding with the second timeout wins and clears retries.
    do_reset("restart_race");
    add(19, 0, 0, W0);
    add(1,  0, 0, R0);
    add(19, 0, 0, W0);
    add(1,  0, 1, R0);
    add(3,  0, 0, R0);
    add(1,  0, 0, W0);
    add(15, 0, 0, W0);
    add(1,  0, 0, R0);
    add(19, 0, 0, W0);
    add(1,  0, 0, F0);
    run_vecs("restart_race");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
